// File: rtl/calc_pkg.sv
// Shared types for the calculator stack unit: opcodes, error codes and control states.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_ADD  = 3'd2,
    OP_MUL  = 3'd3,
    OP_SUB  = 3'd4,
    OP_DIV  = 3'd5,
    OP_MOD  = 3'd6,
    OP_DUP  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ErrNone      = 2'd0,
    ErrOverflow  = 2'd1,
    ErrUnderflow = 2'd2,
    ErrDivZero   = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    StRun = 2'd0,
    StDiv = 2'd1,
    StErr = 2'd2
  } state_t;

  function automatic logic is_div(opcode_t o);
    return (o == OP_DIV) || (o == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses one cycle after the last step.
module calc_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned NW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [NW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH:0]   trial, diff;

  // Remainder is always below the divisor, so the trial value fits in WIDTH+1 bits.
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= '0;
        quo_q  <= dividend;
        dvs_q  <= divisor;
        cnt_q  <= NW'(WIDTH);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (!diff[WIDTH]) begin
          rem_q <= diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - NW'(1);
        if (cnt_q == NW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/calc_stack_unit.sv
// Operand stack with unsigned ALU and multi-cycle divide; entry 0 is top of stack.
// Define CALC_SATURATE_EN to clamp ADD/MUL/SUB results instead of wrapping.
module calc_stack_unit
  import calc_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic             apply,
  output logic             ready,
  output logic [WIDTH-1:0] tail,
  output logic             valid,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [1:0]       err_code
);

  state_t           state_q, state_d;
  err_t             err_q, err_d, cmd_err;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             mod_q, mod_d;

  opcode_t          cmd;
  logic [WIDTH-1:0] a, b, alu_res, wr_val, div_quo, div_rem;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic             accept, div_start, div_busy, div_done, collapse;

  assign cmd       = opcode_t'(op);
  assign a         = stack_q[0];
  assign b         = stack_q[1];
  assign accept    = apply && (state_q == StRun);
  assign div_start = accept && (cmd_err == ErrNone) && is_div(cmd);
  assign sum       = {1'b0, a} + {1'b0, b};
  assign prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_comb begin
    alu_res = sum[WIDTH-1:0];
    case (cmd)
`ifdef CALC_SATURATE_EN
      OP_ADD:  alu_res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      OP_MUL:  alu_res = (|prod[2*WIDTH-1:WIDTH]) ? '1 : prod[WIDTH-1:0];
      OP_SUB:  alu_res = (b > a) ? '0 : a - b;
`else
      OP_ADD:  alu_res = sum[WIDTH-1:0];
      OP_MUL:  alu_res = prod[WIDTH-1:0];
      OP_SUB:  alu_res = a - b;
`endif
      default: alu_res = sum[WIDTH-1:0];
    endcase
  end

  always_comb begin
    cmd_err = ErrNone;
    case (cmd)
      OP_PUSH: if (count_q == CW'(DEPTH)) cmd_err = ErrOverflow;
      OP_POP:  if (count_q == '0) cmd_err = ErrUnderflow;
      OP_DUP: begin
        if (count_q == '0)              cmd_err = ErrUnderflow;
        else if (count_q == CW'(DEPTH)) cmd_err = ErrOverflow;
      end
      default: begin
        if (count_q < CW'(2))           cmd_err = ErrUnderflow;
        else if (is_div(cmd) && b == '0) cmd_err = ErrDivZero;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StRun;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          if (cmd_err != ErrNone) state_d = StErr;
          else if (is_div(cmd))   state_d = StDiv;
        end
      end
      StDiv:   if (div_done) state_d = StRun;
      StErr:   state_d = StErr;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    ready    = (state_q != StDiv) && !div_busy;
    valid    = (state_q != StErr);
    empty    = (count_q == '0);
    tail     = (count_q == '0) ? '0 : stack_q[0];
    count    = count_q;
    err_code = err_q;
  end

  always_comb begin
    stack_d  = stack_q;
    count_d  = count_q;
    err_d    = err_q;
    mod_d    = mod_q;
    collapse = 1'b0;
    wr_val   = alu_res;
    if (accept && cmd_err != ErrNone) begin
      err_d = cmd_err;
    end else if (accept) begin
      unique case (cmd)
        OP_PUSH, OP_DUP: begin
          for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
          stack_d[0] = (cmd == OP_PUSH) ? in : a;
          count_d    = count_q + CW'(1);
        end
        OP_POP: begin
          for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
          stack_d[DEPTH-1] = '0;
          count_d          = count_q - CW'(1);
        end
        OP_DIV, OP_MOD: mod_d = (cmd == OP_MOD);
        default:        collapse = 1'b1;
      endcase
    end else if (state_q == StDiv && div_done) begin
      collapse = 1'b1;
      wr_val   = mod_q ? div_rem : div_quo;
    end
    // Binary result replaces A and B: top gets the result, the rest moves up by one.
    if (collapse) begin
      stack_d[0] = wr_val;
      for (int i = 1; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
      stack_d[DEPTH-1] = '0;
      count_d          = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q   <= ErrNone;
      count_q <= '0;
      mod_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      err_q   <= err_d;
      count_q <= count_d;
      mod_q   <= mod_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_calc_stack_unit.sv
// Scoreboard bench for calc_stack_unit: driver pushes expected outputs, monitor compares after each edge.
module tb_calc_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_v;
  logic [2:0]       op;
  logic             apply;
  logic             ready, valid, empty;
  logic [WIDTH-1:0] tail;
  logic [2:0]       count;
  logic [1:0]       err_code;

  calc_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in_v),
    .op      (op),
    .apply   (apply),
    .ready   (ready),
    .tail    (tail),
    .valid   (valid),
    .empty   (empty),
    .count   (count),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tail;
    int cnt;
    int empty;
    int valid;
    int ready;
    int err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: stack as a queue, top at the back.
  int m_stk[$];
  int m_err  = 0;
  int m_busy = 0;
  bit m_mod  = 0;

  function automatic int alu(input int o, input int a, input int b);
    int r;
    case (o)
      2: r = a + b;
      3: r = a * b;
      default: r = a - b;
    endcase
`ifdef CALC_SATURATE_EN
    if (r > MAXV) r = MAXV;
    if (r < 0) r = 0;
    return r;
`else
    return r & MAXV;
`endif
  endfunction

  task automatic model(input bit r, input bit ap, input int o, input int v);
    int n, a, b;
    if (r) begin
      m_stk.delete();
      m_err  = 0;
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        a = m_stk.pop_back();
        b = m_stk.pop_back();
        m_stk.push_back(m_mod ? a % b : a / b);
      end
    end else if (m_err == 0 && ap) begin
      n = m_stk.size();
      case (o)
        0: if (n == DEPTH) m_err = 1; else m_stk.push_back(v);
        1: if (n == 0) m_err = 2; else void'(m_stk.pop_back());
        7: begin
          if (n == 0) m_err = 2;
          else if (n == DEPTH) m_err = 1;
          else m_stk.push_back(m_stk[n-1]);
        end
        default: begin
          if (n < 2) m_err = 2;
          else begin
            a = m_stk[n-1];
            b = m_stk[n-2];
            if (o == 5 || o == 6) begin
              if (b == 0) m_err = 3;
              else begin
                m_busy = WIDTH + 1;
                m_mod  = (o == 6);
              end
            end else begin
              void'(m_stk.pop_back());
              void'(m_stk.pop_back());
              m_stk.push_back(alu(o, a, b));
            end
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input bit r, input bit ap, input int o, input int v);
    exp_t e;
    @(negedge clk);
    reset = r;
    apply = ap;
    op    = 3'(o);
    in_v  = 8'(v);
    model(r, ap, o, v & MAXV);
    e.cnt   = m_stk.size();
    e.tail  = (e.cnt == 0) ? 0 : m_stk[e.cnt-1];
    e.empty = (e.cnt == 0);
    e.valid = (m_err == 0);
    e.ready = (m_busy == 0);
    e.err   = m_err;
    sb.push_back(e);
  endtask

  task automatic cmd(input int o, input int v);
    cyc(1'b0, 1'b1, o, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0);
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0);
  endtask

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tail", int'(tail), e.tail);
        chk("count", int'(count), e.cnt);
        chk("empty", int'(empty), e.empty);
        chk("valid", int'(valid), e.valid);
        chk("ready", int'(ready), e.ready);
        chk("err_code", int'(err_code), e.err);
      end
    end
  end

  initial begin : driver
    int r, o, v;
    bit ap, rs;
    reset = 1'b1;
    apply = 1'b0;
    op    = 3'd0;
    in_v  = '0;

    rst(1);
    idle(3);

    for (int i = 0; i < 5; i++) cmd(0, 4);
    rst(1);

    cmd(0, 7); cmd(0, 86); cmd(5, 0); idle(10);
    cmd(1, 0);
    cmd(0, 7); cmd(0, 86); cmd(6, 0); idle(10);
    rst(1);

    cmd(0, 4); cmd(0, 4); cmd(2, 0);
    cmd(0, 2); cmd(3, 0);
    cmd(0, 16); cmd(4, 0);
    cmd(1, 0);
    cmd(0, 200); cmd(0, 100); cmd(2, 0);
    cmd(0, 100); cmd(4, 0);
    cmd(0, 255); cmd(3, 0);
    rst(1);

    cmd(0, 0); cmd(0, 86); cmd(5, 0); idle(2);
    rst(1);
    cmd(2, 0); idle(1);
    rst(1);

    cmd(0, 7); cmd(0, 86); cmd(5, 0); idle(2);
    rst(3);
    idle(10);

    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      rs = (m_err != 0) ? (r < 15) : (r < 2);
      ap = ($urandom_range(0, 3) != 0);
      o  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 7);
      v  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      cyc(rs, ap, o, v);
    end
    idle(2);

    @(posedge clk);
    #3;
    chk("scoreboard_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
